// File: rtl/food_gen.sv
// ---------------------------------------------------------------------------
// food_gen -- apple placement and eat detection for the tile-based snake game.
//
// A free-running 16-bit Fibonacci LFSR supplies candidate tile coordinates.
// While placing, one candidate is tried per cycle and accepted when it lies
// inside the playfield and is not under the snake head; after MAX_TRY
// consecutive rejects a fixed corner tile is used instead. Once placed, the
// food waits until the head reaches it during PLAY, then requests ADD_LEN
// cycles of growth, bumps the score and goes back to placing.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        synchronous active-low reset (priority over game_status)
//   game_status  00 RESTART, 10 PLAY, 11 DIE (01 behaves as DIE)
//   head_x/_y    snake head tile column/row
//   pos_x/_y     current VGA pixel; tile index is bits [9:4]
//   add_cube     grow request, held ADD_LEN cycles per apple eaten
//   food_x/_y    food tile column/row
//   food_valid   food is placed and can be eaten
//   food_show    current pixel lies on the food tile (combinational)
//   score        apples eaten, saturates at 99
// ---------------------------------------------------------------------------
module food_gen #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          ADD_LEN = 4,
  parameter int          MAX_TRY = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_status,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       add_cube,
  output logic [5:0] food_x,
  output logic [5:0] food_y,
  output logic       food_valid,
  output logic       food_show,
  output logic [6:0] score
);

  localparam int TRY_W = $clog2(MAX_TRY + 1);

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  localparam logic [5:0] X_MAX     = 6'd38;
  localparam logic [5:0] Y_MAX     = 6'd28;
  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {
    ST_PLACE  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_EAT    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [3:0]       len_q, len_d;
  logic             add_q, add_d;
  logic             valid_q, valid_d;
  logic [5:0]       fx_q, fx_d;
  logic [5:0]       fy_q, fy_d;
  logic [6:0]       score_q, score_d;

  logic [5:0] cand_x;
  logic [5:0] cand_y;
  logic       cand_ok;
  logic       head_on_food;

  // Taps 16,14,13,11 in the right-shifting Fibonacci form: feedback enters at
  // bit 15 and is the XOR of bits 0, 2, 3 and 5.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // The LFSR runs in every game state; only rst_n reseeds it, so a RESTART
  // does not replay the same apple sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign cand_x  = lfsr_q[5:0];
  assign cand_y  = {1'b0, lfsr_q[12:8]};
  assign cand_ok = (cand_x >= 6'd1) && (cand_x <= X_MAX) &&
                   (cand_y >= 6'd1) && (cand_y <= Y_MAX) &&
                   !((cand_x == head_x) && (cand_y == head_y));

  assign head_on_food = (head_x == fx_q) && (head_y == fy_q);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so paths that
    // do not assign it (DIE, waiting states) cannot infer a latch.
    state_d = state_q;
    try_d   = try_q;
    len_d   = len_q;
    add_d   = add_q;
    valid_d = valid_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    score_d = score_q;

    if (game_status == GS_RESTART) begin
      state_d = ST_PLACE;
      try_d   = '0;
      len_d   = '0;
      add_d   = 1'b0;
      valid_d = 1'b0;
      fx_d    = '0;
      fy_d    = '0;
      score_d = '0;
    end else if (game_status == GS_PLAY) begin
      unique case (state_q)
        ST_PLACE: begin
          if (cand_ok) begin
            fx_d    = cand_x;
            fy_d    = cand_y;
            valid_d = 1'b1;
            try_d   = '0;
            state_d = ST_ACTIVE;
          end else if (try_q == TRY_W'(MAX_TRY - 1)) begin
            // Out of draws: take a corner tile, the opposite one if the head
            // already sits on the first.
            if (head_x == 6'd1 && head_y == 6'd1) begin
              fx_d = X_MAX;
              fy_d = Y_MAX;
            end else begin
              fx_d = 6'd1;
              fy_d = 6'd1;
            end
            valid_d = 1'b1;
            try_d   = '0;
            state_d = ST_ACTIVE;
          end else begin
            try_d = try_q + TRY_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (valid_q && head_on_food) begin
            add_d   = 1'b1;
            valid_d = 1'b0;
            len_d   = 4'd1;
            state_d = ST_EAT;
            if (score_q != SCORE_MAX) score_d = score_q + 7'd1;
          end
        end
        ST_EAT: begin
          // len_q counts cycles add_cube has already been high.
          if (len_q == 4'(ADD_LEN)) begin
            add_d   = 1'b0;
            len_d   = '0;
            state_d = ST_PLACE;
          end else begin
            len_d = len_q + 4'd1;
          end
        end
        default: state_d = ST_PLACE;
      endcase
    end
    // Any other status (DIE, 01) holds everything except the LFSR.
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PLACE;
      try_q   <= '0;
      len_q   <= '0;
      add_q   <= 1'b0;
      valid_q <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
      len_q   <= len_d;
      add_q   <= add_d;
      valid_q <= valid_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      score_q <= score_d;
    end
  end

  assign add_cube   = add_q;
  assign food_x     = fx_q;
  assign food_y     = fy_q;
  assign food_valid = valid_q;
  assign score      = score_q;

  assign food_show = valid_q && (pos_x < 10'd640) && (pos_y < 10'd480) &&
                     (pos_x[9:4] == fx_q) && (pos_y[9:4] == fy_q);

endmodule

// File: doc/food_gen.md
FOOD_GEN -- requirements
Module: food_gen

Interface
REQ-001 SHALL have parameter SEED, 16'hACE1, nonzero LFSR reset value.
REQ-002 SHALL have parameter ADD_LEN, 4, cycles add_cube is held high per eat event (legal 1..15).
REQ-003 SHALL have parameter MAX_TRY, 64, rejected placement draws before fallback placement.
REQ-004 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 game_status  input  2  00 RESTART, 10 PLAY, 11 DIE; 01 treated as DIE.
REQ-007 head_x  input  6  snake head tile column (1..38 in play).
REQ-008 head_y  input  6  snake head tile row (1..28 in play).
REQ-009 pos_x  input  10  VGA pixel column; tile = pos_x[9:4].
REQ-010 pos_y  input  10  VGA pixel row; tile = pos_y[9:4].
REQ-011 add_cube  output  1  grow request to snake, registered, level held ADD_LEN cycles.
REQ-012 food_x  output  6  food tile column, registered.
REQ-013 food_y  output  6  food tile row, registered.
REQ-014 food_valid  output  1  food placed and edible, registered.
REQ-015 food_show  output  1  combinational: current pixel lies on food tile.
REQ-016 score  output  7  apples eaten, registered, saturating at 99.

Function
REQ-017 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every clk cycle in every state, reseeded only by rst_n (not by RESTART).
REQ-018 SHALL implement FSM states PLACE, ACTIVE, EAT.
REQ-019 PLACE: each cycle candidate x = lfsr[5:0], y = {1'b0, lfsr[12:8]}; accept when 1<=x<=38, 1<=y<=28, and (x,y) != (head_x,head_y).
REQ-020 PLACE accept: next cycle food_x/food_y = candidate, food_valid=1, try counter cleared, state -> ACTIVE.
REQ-021 PLACE reject: try counter +1; on MAX_TRY-th consecutive reject SHALL place at (1,1), or (38,28) if head is at (1,1), then -> ACTIVE.
REQ-022 ACTIVE: when game_status==PLAY and head_x==food_x and head_y==food_y, next cycle add_cube=1, food_valid=0, score+1 (hold at 99), state -> EAT.
REQ-023 ACTIVE with match but game_status!=PLAY SHALL take no action.
REQ-024 EAT: add_cube SHALL stay high exactly ADD_LEN cycles total, then drop to 0 on the same edge the state -> PLACE; add_cube therefore low >=1 cycle before any following assertion.
REQ-025 Exactly one add_cube assertion per eat event; head remaining on old food tile SHALL NOT retrigger (food_valid=0 until new placement).
REQ-026 DIE (or 01): FSM, food_x/y, food_valid, score, add_cube SHALL hold; LFSR keeps running; an in-progress EAT freezes with add_cube held.
REQ-027 RESTART (rst_n high): next cycle state=PLACE, add_cube=0, food_valid=0, food_x=food_y=0, score=0, try counter=0; overrides any state incl. EAT.
REQ-028 food_show = food_valid && pos_x<640 && pos_y<480 && pos_x[9:4]==food_x && pos_y[9:4]==food_y.
REQ-029 Placement SHALL check head only; body overlap is permitted.

Reset
REQ-030 rst_n=0 at a clk edge: lfsr=SEED, state=PLACE, add_cube=0, food_valid=0, food_x=0, food_y=0, score=0, try counter=0; rst_n has priority over game_status.
REQ-031 Reset mid-EAT SHALL drop add_cube the following edge without incrementing score further.

Verification
REQ-032 Reset then game_status=10, head (10,20): food_valid=1 within MAX_TRY+1 cycles, food in 1..38 x 1..28, food != (10,20), position matches LFSR reference model from 16'hACE1.
REQ-033 Drive head onto food in PLAY: add_cube high for exactly 4 cycles starting 1 cycle after match, score 0->1, food_valid low during EAT, new food placed afterward; head held on old tile causes no second pulse.
REQ-034 Same match with game_status=11: add_cube stays 0, score unchanged; switch to 10 -> eat occurs next cycle.
REQ-035 game_status=00 asserted during EAT cycle 2: next cycle add_cube=0, score=0, food_valid=0; return to 10 -> new placement.
REQ-036 Force 100 eat events: score saturates at 99, add_cube still pulses each event.
REQ-037 Sweep pos_x/pos_y over frame with food (5,7): food_show high only for pos_x 80..95, pos_y 112..127; low for pos_x>=640 or pos_y>=480.
